// File: rtl/wb_commit_ctrl.sv
// Registered writeback-stage controller: resolves destination and data source, waits for load data, drives the RF write port.
// Optional W-stage forwarding outputs are built when WB_FWD_EN is defined.
module wb_commit_ctrl #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LINK_OFS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_regwe,
    input  logic [1:0]    in_wadrs,
    input  logic [2:0]    in_wdsrc,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    input  logic [DW-1:0] in_alures,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_cp0,
    input  logic [DW-1:0] in_hi,
    input  logic [DW-1:0] in_lo,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    input  logic          flush,
`ifdef WB_FWD_EN
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          regwe_q, regwe_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          accept_s;
    logic          is_load_s;

    assign in_ready  = !reset && (state_q != S_WAIT);
    assign accept_s  = in_valid && in_ready && !flush;
    assign is_load_s = (in_wdsrc == 3'd1) && in_regwe;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush beats mem_rvalid while waiting
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE, S_COMMIT: begin
                if (accept_s) begin
                    state_d = is_load_s ? S_WAIT : S_COMMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_rvalid) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/next-data logic: latch destination and data on acceptance, load data on mem_rvalid
    always_comb begin
        regwe_d = regwe_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept_s) begin
            regwe_d = in_regwe;
            case (in_wadrs)
                2'd0:    waddr_d = in_rt;
                2'd1:    waddr_d = in_rd;
                2'd2:    waddr_d = {AW{1'b1}};
                default: waddr_d = in_rd;
            endcase
            case (in_wdsrc)
                3'd0:    wdata_d = in_alures;
                3'd1:    wdata_d = {DW{1'b0}};
                3'd2:    wdata_d = in_pc + DW'(LINK_OFS);
                3'd3:    wdata_d = in_cp0;
                3'd4:    wdata_d = in_hi;
                3'd5:    wdata_d = in_lo;
                default: wdata_d = in_alures;
            endcase
        end else if ((state_q == S_WAIT) && !flush && mem_rvalid) begin
            wdata_d = mem_rdata;
        end else begin
            wdata_d = wdata_q;
        end
        we_d   = (state_d == S_COMMIT) && regwe_d && (waddr_d != {AW{1'b0}});
        busy_d = (state_d == S_WAIT);
    end

    // Registered write port and latched instruction fields
    always_ff @(posedge clk) begin
        if (reset) begin
            regwe_q <= 1'b0;
            waddr_q <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            regwe_q <= regwe_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign busy     = busy_q;

`ifdef WB_FWD_EN
    assign fwd_valid = we_q;
    assign fwd_addr  = waddr_q;
    assign fwd_data  = wdata_q;
`endif

endmodule
